// File: rtl/sparse_node_queue.sv
// Two-bank node-vector queue that serialises each vector as (index, value) pairs, optionally skipping zeros.
// Latency: load at edge N -> first element at edge N+1; load_ready is registered-only, outputs hold while out_ready=0.
module sparse_node_queue #(
  parameter int NODES  = 16,
  parameter int DATA_W = 8,
  parameter int IDX_W  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [NODES*DATA_W-1:0] load_data,
  input  logic                    skip_en,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [IDX_W-1:0]        out_index,
  output logic [DATA_W-1:0]       out_value,
  output logic                    out_last,
  output logic                    vec_done
);

  localparam int SEL_W = $clog2(NODES);

  logic [DATA_W-1:0] bankData [2][NODES];
  logic [1:0]        bankFull;
  logic [NODES-1:0]  bankPending [2];
  logic              wrBank;
  logic              rdBank;

  logic              outValid;
  logic              outLast;
  logic              vecDone;
  logic [IDX_W-1:0]  outIndex;
  logic [DATA_W-1:0] outValue;

  logic [NODES-1:0]  loadMask;
  logic [NODES-1:0]  rdPending;
  logic [NODES-1:0]  rdRemain;
  logic [SEL_W-1:0]  pickSel;
  logic              rdFull;
  logic              pickFound;
  logic              lastPick;
  logic              advance;
  logic              emit;
  logic              lastHandshake;
  logic              zeroRelease;
  logic              bankRelease;
  logic              loadFire;

  assign load_ready = !bankFull[wrBank];
  assign loadFire   = load_valid & load_ready & !flush;

  always_comb begin
    loadMask = '1;
    for (int i = 0; i < NODES; i++) begin
      if (skip_en) begin
        loadMask[i] = |load_data[(NODES-1-i)*DATA_W +: DATA_W];
      end
    end
  end

  assign rdPending = bankPending[rdBank];
  assign rdFull    = bankFull[rdBank];
  assign pickFound = |rdPending;
  // Clearing the lowest set bit leaves exactly the nodes still owed after this pick.
  assign rdRemain  = rdPending & (rdPending - NODES'(1));
  assign lastPick  = (rdRemain == '0);

  always_comb begin
    pickSel = '0;
    for (int i = NODES - 1; i >= 0; i--) begin
      if (rdPending[i]) begin
        pickSel = SEL_W'(i);
      end
    end
  end

  assign advance       = !outValid | out_ready;
  assign emit          = advance & rdFull & pickFound;
  assign lastHandshake = outValid & out_ready & outLast;
  // An all-zero bank retires only when it cannot collide with a last-element handshake, so no vec_done is lost.
  assign zeroRelease   = rdFull & !pickFound & !lastHandshake;
  assign bankRelease   = (emit & lastPick) | zeroRelease;

  always_ff @(posedge clk) begin
    if (loadFire) begin
      for (int i = 0; i < NODES; i++) begin
        bankData[wrBank][i] <= load_data[(NODES-1-i)*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bankFull       <= '0;
      bankPending[0] <= '0;
      bankPending[1] <= '0;
      wrBank         <= 1'b0;
      rdBank         <= 1'b0;
      outValid       <= 1'b0;
      outLast        <= 1'b0;
      outIndex       <= '0;
      outValue       <= '0;
      vecDone        <= 1'b0;
    end else if (flush) begin
      bankFull       <= '0;
      bankPending[0] <= '0;
      bankPending[1] <= '0;
      wrBank         <= 1'b0;
      rdBank         <= 1'b0;
      outValid       <= 1'b0;
      outLast        <= 1'b0;
      vecDone        <= 1'b0;
    end else begin
      vecDone <= lastHandshake | zeroRelease;

      // A free write bank can never be the full read bank, so load and drain never touch the same bank.
      if (loadFire) begin
        bankFull[wrBank]    <= 1'b1;
        bankPending[wrBank] <= loadMask;
        wrBank              <= ~wrBank;
      end

      if (emit) begin
        bankPending[rdBank] <= rdRemain;
        outValid            <= 1'b1;
        outIndex            <= IDX_W'(pickSel);
        outValue            <= bankData[rdBank][pickSel];
        outLast             <= lastPick;
      end else if (advance) begin
        outValid <= 1'b0;
      end

      if (bankRelease) begin
        bankFull[rdBank] <= 1'b0;
        rdBank           <= ~rdBank;
      end
    end
  end

  assign out_valid = outValid;
  assign out_index = outIndex;
  assign out_value = outValue;
  assign out_last  = outLast;
  assign vec_done  = vecDone;

endmodule

// File: tb/tb_sparse_node_queue.sv
// Bench for sparse_node_queue (NODES=4): vector table, hand-written corner sequences, randomized scoreboard run.
module tb_sparse_node_queue;

  localparam int NODES  = 4;
  localparam int DATA_W = 8;
  localparam int IDX_W  = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              flush;
  logic              load_valid;
  logic              load_ready;
  logic [31:0]       load_data;
  logic              skip_en;
  logic              out_valid;
  logic              out_ready;
  logic [IDX_W-1:0]  out_index;
  logic [DATA_W-1:0] out_value;
  logic              out_last;
  logic              vec_done;

  sparse_node_queue #(.NODES(NODES), .DATA_W(DATA_W), .IDX_W(IDX_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .skip_en    (skip_en),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_index  (out_index),
    .out_value  (out_value),
    .out_last   (out_last),
    .vec_done   (vec_done)
  );

  always #5 clk = ~clk;

  // Expected elements listed in emission order: element j at idx[j*2 +: 2] / val[j*8 +: 8].
  typedef struct packed {
    logic [31:0] data;
    logic        skip;
    logic [2:0]  n;
    logic [7:0]  idx;
    logic [31:0] val;
  } vec_t;

  typedef struct packed {
    logic [1:0] idx;
    logic [7:0] val;
    logic       last;
  } elem_t;

  int    total = 0;
  int    bad   = 0;
  vec_t  tbl [6];
  elem_t modelQ [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic runVector(input vec_t v, input int t);
    load_valid = 1'b1;
    load_data  = v.data;
    skip_en    = v.skip;
    out_ready  = 1'b1;
    tick;
    load_valid = 1'b0;
    check($sformatf("vec%0d idle after load", t), 32'(out_valid), 32'd0);
    for (int j = 0; j < int'(v.n); j++) begin
      tick;
      check($sformatf("vec%0d e%0d valid", t, j), 32'(out_valid), 32'd1);
      check($sformatf("vec%0d e%0d index", t, j), 32'(out_index), 32'(v.idx[j*2 +: 2]));
      check($sformatf("vec%0d e%0d value", t, j), 32'(out_value), 32'(v.val[j*8 +: 8]));
      check($sformatf("vec%0d e%0d last", t, j), 32'(out_last), 32'(j == int'(v.n) - 1));
      check($sformatf("vec%0d e%0d vec_done", t, j), 32'(vec_done), 32'd0);
    end
    tick;
    check($sformatf("vec%0d done pulse", t), 32'(vec_done), 32'd1);
    check($sformatf("vec%0d valid after", t), 32'(out_valid), 32'd0);
    tick;
    check($sformatf("vec%0d done cleared", t), 32'(vec_done), 32'd0);
  endtask

  // Reference: a vector contributes its nodes in index order, dropping zeros only when skip is set.
  task automatic modelLoad(input logic [31:0] data, input logic skip);
    elem_t tmp [$];
    elem_t e;
    logic [7:0] node;
    for (int i = 0; i < NODES; i++) begin
      node = data[(NODES-1-i)*8 +: 8];
      if (!skip || node != 8'd0) begin
        e.idx  = 2'(i);
        e.val  = node;
        e.last = 1'b0;
        tmp.push_back(e);
      end
    end
    if (tmp.size() > 0) tmp[tmp.size()-1].last = 1'b1;
    foreach (tmp[k]) modelQ.push_back(tmp[k]);
  endtask

  task automatic scoreHandshake;
    elem_t e;
    if (out_valid && out_ready) begin
      if (modelQ.size() == 0) begin
        check("rand unexpected out", 32'(out_valid), 32'd0);
      end else begin
        e = modelQ.pop_front();
        check("rand elem", 32'({out_index, out_value, out_last}), 32'({e.idx, e.val, e.last}));
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rdat;
    logic        rskip;
    logic        prevStall;
    logic [10:0] prevOut;
    int          expVec;
    int          gotVec;

    tbl[0] = '{32'h05000703, 1'b0, 3'd4, {2'd3, 2'd2, 2'd1, 2'd0}, {8'd3, 8'd7, 8'd0, 8'd5}};
    tbl[1] = '{32'h05000703, 1'b1, 3'd3, {2'd0, 2'd3, 2'd2, 2'd0}, {8'd0, 8'd3, 8'd7, 8'd5}};
    tbl[2] = '{32'h00000009, 1'b1, 3'd1, {2'd0, 2'd0, 2'd0, 2'd3}, {8'd0, 8'd0, 8'd0, 8'd9}};
    tbl[3] = '{32'h01020304, 1'b1, 3'd4, {2'd3, 2'd2, 2'd1, 2'd0}, {8'd4, 8'd3, 8'd2, 8'd1}};
    tbl[4] = '{32'h00080000, 1'b0, 3'd4, {2'd3, 2'd2, 2'd1, 2'd0}, {8'd0, 8'd0, 8'd8, 8'd0}};
    tbl[5] = '{32'h0000ff00, 1'b1, 3'd1, {2'd0, 2'd0, 2'd0, 2'd2}, {8'd0, 8'd0, 8'd0, 8'hff}};

    reset      = 1'b1;
    flush      = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    skip_en    = 1'b0;
    out_ready  = 1'b0;
    #2;
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset out_index", 32'(out_index), 32'd0);
    check("reset out_value", 32'(out_value), 32'd0);
    check("reset out_last", 32'(out_last), 32'd0);
    check("reset vec_done", 32'(vec_done), 32'd0);
    check("reset load_ready", 32'(load_ready), 32'd1);
    tick;
    tick;
    reset = 1'b0;
    tick;

    for (int t = 0; t < 6; t++) runVector(tbl[t], t);

    // All-zero vector with skip: no element, a single vec_done, bank free again.
    load_valid = 1'b1; load_data = 32'h0; skip_en = 1'b1; out_ready = 1'b1;
    tick;
    load_valid = 1'b0;
    check("zero vec no valid", 32'(out_valid), 32'd0);
    check("zero vec no done yet", 32'(vec_done), 32'd0);
    tick;
    check("zero vec done", 32'(vec_done), 32'd1);
    check("zero vec valid", 32'(out_valid), 32'd0);
    check("zero vec load_ready", 32'(load_ready), 32'd1);
    tick;
    check("zero vec done once", 32'(vec_done), 32'd0);

    // Stalled consumer: outputs hold, second load taken, third waits for the first bank.
    load_valid = 1'b1; load_data = 32'h01020304; skip_en = 1'b0; out_ready = 1'b0;
    tick;
    check("stall second bank free", 32'(load_ready), 32'd1);
    load_data = 32'h09080706;
    tick;
    check("stall first valid", 32'(out_valid), 32'd1);
    check("stall first value", 32'(out_value), 32'd1);
    check("stall banks full", 32'(load_ready), 32'd0);
    load_data = 32'h0a0b0c0d;
    for (int k = 0; k < 3; k++) begin
      tick;
      check($sformatf("stall hold%0d", k), 32'({out_valid, out_index, out_value, out_last}), 32'({1'b1, 2'd0, 8'd1, 1'b0}));
      check($sformatf("stall load_ready%0d", k), 32'(load_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick;
    check("stall resume e1", 32'({out_index, out_value, load_ready}), 32'({2'd1, 8'd2, 1'b0}));
    tick;
    check("stall resume e2", 32'({out_index, out_value, load_ready}), 32'({2'd2, 8'd3, 1'b0}));
    tick;
    check("stall resume e3", 32'({out_index, out_value, out_last, load_ready}), 32'({2'd3, 8'd4, 1'b1, 1'b1}));
    tick;
    load_valid = 1'b0;
    check("stall next vector", 32'({out_valid, out_index, out_value}), 32'({1'b1, 2'd0, 8'd9}));
    check("stall vec_done", 32'(vec_done), 32'd1);
    flush = 1'b1;
    tick;
    flush = 1'b0;
    check("flush clears valid", 32'(out_valid), 32'd0);
    check("flush load_ready", 32'(load_ready), 32'd1);
    tick;
    check("flush banks empty", 32'(out_valid), 32'd0);

    // Reset mid-drain with a second vector queued.
    load_valid = 1'b1; load_data = 32'h05000703; skip_en = 1'b0; out_ready = 1'b1;
    tick;
    load_data = 32'h01020304;
    tick;
    load_valid = 1'b0;
    tick;
    check("pre-reset index", 32'(out_index), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("midreset outputs", 32'({out_valid, out_index, out_value, out_last, vec_done}), 32'd0);
    check("midreset load_ready", 32'(load_ready), 32'd1);
    tick;
    tick;
    reset = 1'b0;
    tick;
    check("post-reset idle", 32'(out_valid), 32'd0);
    runVector(tbl[0], 10);

    // Flush together with a load while draining: load dropped, no vec_done.
    load_valid = 1'b1; load_data = 32'h01020304; skip_en = 1'b0; out_ready = 1'b1;
    tick;
    load_valid = 1'b0;
    tick;
    check("flushload draining", 32'(out_valid), 32'd1);
    flush = 1'b1; load_valid = 1'b1; load_data = 32'h0f0f0f0f;
    tick;
    flush = 1'b0; load_valid = 1'b0;
    check("flushload valid", 32'(out_valid), 32'd0);
    check("flushload last", 32'(out_last), 32'd0);
    check("flushload load_ready", 32'(load_ready), 32'd1);
    check("flushload vec_done", 32'(vec_done), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick;
      check($sformatf("flushload dropped%0d", k), 32'({out_valid, vec_done}), 32'd0);
    end

    // Randomized traffic against the reference queue.
    reset = 1'b1;
    tick;
    reset = 1'b0;
    tick;
    modelQ.delete();
    expVec    = 0;
    gotVec    = 0;
    prevStall = 1'b0;
    prevOut   = '0;
    for (int c = 0; c < 3000; c++) begin
      if (prevStall)
        check("rand stall hold", 32'({out_valid, out_index, out_value, out_last}), 32'({1'b1, prevOut}));
      if (vec_done) gotVec++;
      out_ready = ($urandom_range(0, 9) < 7);
      scoreHandshake();
      load_valid = $urandom_range(0, 1);
      for (int i = 0; i < 4; i++)
        rdat[i*8 +: 8] = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      rskip      = $urandom_range(0, 1);
      load_data  = rdat;
      skip_en    = rskip;
      if (load_valid && load_ready) begin
        modelLoad(rdat, rskip);
        expVec++;
      end
      prevStall = out_valid && !out_ready;
      prevOut   = {out_index, out_value, out_last};
      tick;
    end
    load_valid = 1'b0;
    out_ready  = 1'b1;
    for (int c = 0; c < 60; c++) begin
      if (vec_done) gotVec++;
      scoreHandshake();
      tick;
    end
    check("rand queue drained", 32'(modelQ.size()), 32'd0);
    check("rand vec_done count", 32'(gotVec), 32'(expVec));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
